serial_ripple_subtractor: RTL and testbench



---
 rtl/serial_ripple_subtractor.sv | 85 ++++++++
 tb/tb_serial_ripple_subtractor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial borrow-ripple subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// Start/busy/done handshake; Diff and Bout update only on the completion edge.
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic bit_a;
  logic bit_b;
  logic d;
  logic br_next;

  // Single full-subtractor stage operating on the current LSBs.
  assign bit_a   = a_sr[0];
  assign bit_b   = b_sr[0];
  assign d       = bit_a ^ bit_b ^ br;
  assign br_next = (~bit_a & bit_b) | (~bit_a & br) | (bit_b & br);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      Diff   <= '0;
      Bout   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            br     <= Bin;
            cnt    <= '0;
            res_sr <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          br     <= br_next;
          res_sr <= {d, res_sr[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          // Last bit: publish the result including this cycle's difference bit.
          if (cnt == CW'(WIDTH - 1)) begin
            Diff  <= {d, res_sr[WIDTH-1:1]};
            Bout  <= br_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed bench for serial_ripple_subtractor (WIDTH=4): vector table plus
// hand-written sequences for ignored start, mid-run reset and back-to-back use.
module tb_serial_ripple_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a),
    .B     (b),
    .Bin   (bin),
    .busy  (busy),
    .done  (done),
    .Diff  (diff),
    .Bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Accept one operation, then track it to done: checks latency, busy count and result.
  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vbin, input logic [W-1:0] ediff, input logic ebout);
    int edges;
    int busy_cycles;
    @(negedge clk);
    a = va; b = vb; bin = vbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    busy_cycles = 0;
    if (busy) busy_cycles++;
    while (!done && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cycles++;
    end
    check({name, " done_seen"}, int'(done), 1);
    check({name, " latency"}, edges, W);
    check({name, " busy_cycles"}, busy_cycles, W);
    check({name, " busy_in_done"}, int'(busy), 0);
    check({name, " diff"}, int'(diff), int'(ediff));
    check({name, " bout"}, int'(bout), int'(ebout));
    @(posedge clk); #1;
    check({name, " done_one_cycle"}, int'(done), 0);
  endtask

  initial begin
    int t1;
    int t2;
    int k;
    int dones;
    logic [W-1:0] d1;
    logic [W-1:0] d2;

    vecs[0] = '{"4-1",      4'b0100, 4'b0001, 1'b0, 4'b0011, 1'b0};
    vecs[1] = '{"3-5",      4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1};
    vecs[2] = '{"0-0-1",    4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1};
    vecs[3] = '{"15-15",    4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0};
    vecs[4] = '{"6-10",     4'b0110, 4'b1010, 1'b0, 4'b1100, 1'b1};
    vecs[5] = '{"15-15-1",  4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset diff", int'(diff), 0);
    check("reset bout", int'(bout), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout);
      $display("op %s: diff=%b bout=%b", vecs[i].name, diff, bout);
    end

    // Ignored start: Diff holds 1111 from the last vector until 4-1 completes.
    @(negedge clk);
    a = 4'b0100; b = 4'b0001; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 4'b1001; b = 4'b0010; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign diff_hold_a", int'(diff), 4'hF);
    @(posedge clk); #1;
    check("ign diff_hold_b", int'(diff), 4'hF);
    check("ign not_done_early", int'(done), 0);
    @(posedge clk); #1;
    check("ign done_on_time", int'(done), 1);
    check("ign diff", int'(diff), 4'b0011);
    check("ign bout", int'(bout), 0);
    @(posedge clk); #1;
    check("ign no_second_op", int'(busy), 0);
    $display("op ignored-start: diff=%b bout=%b", diff, bout);

    // Mid-run reset at the second RUN cycle, with Diff=0011 held beforehand.
    @(negedge clk);
    a = 4'b0011; b = 4'b0101; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst diff", int'(diff), 0);
    check("rst bout", int'(bout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("rst no_done", dones, 0);
    $display("op mid-run reset: done pulses after reset=%0d", dones);
    run_op("after_rst 3-5", 4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1);

    // Back-to-back with start held high across the first done cycle.
    @(negedge clk);
    a = 4'b0100; b = 4'b0001; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 4'b0011; b = 4'b0101;
    t1 = -1; t2 = -1; d1 = '0; d2 = '0;
    k = 0;
    while (t2 < 0 && k < 30) begin
      @(posedge clk); #1;
      k++;
      if (t1 >= 0 && k == t1 + 1) start = 1'b0;
      if (done && t1 < 0) begin t1 = k; d1 = diff; end
      else if (done) begin t2 = k; d2 = diff; end
      if (busy === done) begin
        n_fail++;
        $display("FAIL b2b busy_vs_done at k=%0d: busy=%b done=%b", k, busy, done);
      end
      n_cmp++;
    end
    start = 1'b0;
    check("b2b both_done", int'(t1 >= 0 && t2 >= 0), 1);
    check("b2b spacing", t2 - t1, W + 1);
    check("b2b diff1", int'(d1), 4'b0011);
    check("b2b diff2", int'(d2), 4'b1110);
    $display("op back-to-back: diff1=%b diff2=%b spacing=%0d", d1, d2, t2 - t1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
